cpu16_regfile_wb: RTL and testbench

- Register file and writeback sequencer for the 16-bit CPU datapath, with synchronous read ports and write forwarding.
- Three read ports supply the ALU operands op1, op2 and op3, one cycle after the address is presented.
- The write port takes ALU results (out, out2) plus the z/c flags and commits them to the registers and a flags register.
- Wide results (MUL/DIV/REM, where out2 is valid) are written as a register pair over two cycles by a small state machine.

---
 rtl/cpu16_regfile_wb.sv | 150 +++++++++++++++
 tb/tb_cpu16_regfile_wb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu16_regfile_wb.sv
// cpu16_regfile_wb: register file and writeback sequencer for the 16-bit CPU.
// Provides three registered read ports with same-cycle write forwarding and
// one write port. Wide results (lo/hi pair) are committed over two cycles.
// Optional build macro: REG0_ZERO_EN makes r0 read as zero and drops writes to it.
module cpu16_regfile_wb #(
  parameter int BITS = 16,
  parameter int REGS = 16,
  localparam int AW = $clog2(REGS)
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic [AW-1:0]   ra3,
  output logic [BITS-1:0] rd1,
  output logic [BITS-1:0] rd2,
  output logic [BITS-1:0] rd3,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic            wb_wide,
  input  logic [BITS-1:0] wb_lo,
  input  logic [BITS-1:0] wb_hi,
  input  logic            wb_flags_en,
  input  logic            z_in,
  input  logic            c_in,
  output logic            busy,
  output logic            flag_z,
  output logic            flag_c
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WRITE_HI = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [BITS-1:0] hi_data_q, hi_data_d;
  logic [AW-1:0]   hi_addr_q, hi_addr_d;
  logic            flag_z_q, flag_z_d;
  logic            flag_c_q, flag_c_d;
  logic [BITS-1:0] regs_q [REGS];

  logic            wr_req;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [BITS-1:0] wr_data;

  logic [AW-1:0]   ra_arr [3];
  logic [BITS-1:0] rd_d   [3];
  logic [BITS-1:0] rd1_q, rd2_q, rd3_q;

  assign ra_arr[0] = ra1;
  assign ra_arr[1] = ra2;
  assign ra_arr[2] = ra3;

  // Select the single write performed this cycle: lo word in IDLE, pending hi word in WRITE_HI.
  always_comb begin
    wr_req  = 1'b0;
    wr_addr = wb_rd;
    wr_data = wb_lo;
    if (state_q == ST_WRITE_HI) begin
      wr_req  = 1'b1;
      wr_addr = hi_addr_q;
      wr_data = hi_data_q;
    end else begin
      wr_req  = wb_valid;
    end
  end

`ifdef REG0_ZERO_EN
  // r0 is hardwired: suppressing the write also suppresses forwarding to r0.
  assign wr_en = wr_req && (wr_addr != '0);
`else
  assign wr_en = wr_req;
`endif

  // Sequencer next state, hi-word latch and flag capture (flags only in the lo cycle).
  always_comb begin
    state_d   = state_q;
    hi_data_d = hi_data_q;
    hi_addr_d = hi_addr_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    if (state_q == ST_WRITE_HI) begin
      state_d = ST_IDLE;
    end else if (wb_valid) begin
      if (wb_flags_en) begin
        flag_z_d = z_in;
        flag_c_d = c_in;
      end
      if (wb_wide) begin
        state_d   = ST_WRITE_HI;
        hi_data_d = wb_hi;
        hi_addr_d = (wb_rd == AW'(REGS - 1)) ? '0 : wb_rd + 1'b1;
      end
    end
  end

  // Sequencer and flag registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      hi_data_q <= '0;
      hi_addr_q <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_data_q <= hi_data_d;
      hi_addr_q <= hi_addr_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
    end
  end

  // Register array write; cleared on reset so a pending hi write is simply lost.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < REGS; i++) begin
        if (wr_en && (wr_addr == AW'(i))) regs_q[i] <= wr_data;
      end
    end
  end

  // Per-port read mux with forwarding of the word being written this cycle.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rd
    assign rd_d[gi] = (wr_en && (ra_arr[gi] == wr_addr)) ? wr_data : regs_q[ra_arr[gi]];
  end

  // Registered read data.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd1_q <= '0;
      rd2_q <= '0;
      rd3_q <= '0;
    end else begin
      rd1_q <= rd_d[0];
      rd2_q <= rd_d[1];
      rd3_q <= rd_d[2];
    end
  end

  assign rd1    = rd1_q;
  assign rd2    = rd2_q;
  assign rd3    = rd3_q;
  assign busy   = (state_q == ST_WRITE_HI);
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

endmodule

// File: tb/tb_cpu16_regfile_wb.sv
// Testbench for cpu16_regfile_wb: directed vectors, expectations queued in a
// scoreboard and checked by a monitor one time step after each rising edge.
module tb_cpu16_regfile_wb;

  logic        clk = 1'b0;
  logic        nreset;
  logic [3:0]  ra1, ra2, ra3;
  logic [15:0] rd1, rd2, rd3;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        wb_wide;
  logic [15:0] wb_lo, wb_hi;
  logic        wb_flags_en, z_in, c_in;
  logic        busy, flag_z, flag_c;

  cpu16_regfile_wb dut (
    .clk(clk), .nreset(nreset),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wide(wb_wide),
    .wb_lo(wb_lo), .wb_hi(wb_hi),
    .wb_flags_en(wb_flags_en), .z_in(z_in), .c_in(c_in),
    .busy(busy), .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  // Observable kinds.
  localparam int K_RD1 = 0, K_RD2 = 1, K_RD3 = 2, K_BUSY = 3, K_FZ = 4, K_FC = 5;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef REG0_ZERO_EN
  localparam logic [15:0] WRAP_R0 = 16'h0000;
`else
  localparam logic [15:0] WRAP_R0 = 16'h00FF;
`endif

  function automatic logic [15:0] actual(int kind);
    case (kind)
      K_RD1:   return rd1;
      K_RD2:   return rd2;
      K_RD3:   return rd3;
      K_BUSY:  return {15'd0, busy};
      K_FZ:    return {15'd0, flag_z};
      default: return {15'd0, flag_c};
    endcase
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Queue an expectation for the next rising edge.
  task automatic expect_next(int kind, logic [15:0] exp, string name);
    exp_t e;
    e.due  = edge_cnt + 1;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_wide = 1'b0; wb_flags_en = 1'b0;
    z_in = 1'b0; c_in = 1'b0; wb_rd = 4'd0; wb_lo = 16'h0; wb_hi = 16'h0;
  endtask

  // Monitor: counts edges and checks every expectation that has come due.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      while (q.size() > 0 && q[0].due <= edge_cnt) begin
        exp_t e;
        e = q.pop_front();
        check(e.name, actual(e.kind), e.exp);
      end
    end
  end

  // Global time bound.
  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    nreset = 1'b0;
    ra1 = 4'd0; ra2 = 4'd0; ra3 = 4'd0;
    idle_inputs();
    tick(); tick();
    nreset = 1'b1;
    tick();

    // Preload r3 and set both flags; forwarded read of r3.
    wb_valid = 1; wb_rd = 4'd3; wb_lo = 16'h1234; wb_flags_en = 1; z_in = 1; c_in = 1; ra1 = 4'd3;
    expect_next(K_RD1, 16'h1234, "preload_fwd_rd1");
    expect_next(K_FZ, 16'd1, "preload_flag_z");
    expect_next(K_FC, 16'd1, "preload_flag_c");
    tick();
    idle_inputs();
    ra2 = 4'd3; ra3 = 4'd3;
    expect_next(K_RD2, 16'h1234, "preload_rd2");
    expect_next(K_RD3, 16'h1234, "preload_rd3");
    tick();

    // Asynchronous reset mid-cycle: outputs clear immediately.
    #2 nreset = 1'b0;
    #1;
    check("rst_rd1", rd1, 16'h0);
    check("rst_rd2", rd2, 16'h0);
    check("rst_rd3", rd3, 16'h0);
    check("rst_flag_z", {15'd0, flag_z}, 16'h0);
    check("rst_flag_c", {15'd0, flag_c}, 16'h0);
    check("rst_busy", {15'd0, busy}, 16'h0);
    tick();
    nreset = 1'b1;
    ra1 = 4'd3;
    expect_next(K_RD1, 16'h0, "rst_r3_cleared");
    tick();

    // Narrow write with same-edge forwarding, then normal read.
    wb_valid = 1; wb_rd = 4'd5; wb_lo = 16'hBEEF; ra1 = 4'd5;
    expect_next(K_RD1, 16'hBEEF, "narrow_fwd_rd1");
    expect_next(K_BUSY, 16'd0, "narrow_busy");
    tick();
    idle_inputs();
    ra2 = 4'd5;
    expect_next(K_RD2, 16'hBEEF, "narrow_rd2");
    tick();

    // Wide write r2/r3; during WRITE_HI a dropped request to r7 is ignored.
    wb_valid = 1; wb_rd = 4'd2; wb_wide = 1; wb_lo = 16'h5678; wb_hi = 16'h1234; ra1 = 4'd2;
    expect_next(K_RD1, 16'h5678, "wide_lo_fwd_rd1");
    expect_next(K_BUSY, 16'd1, "wide_busy_hi");
    tick();
    wb_valid = 1; wb_rd = 4'd7; wb_wide = 0; wb_lo = 16'hAAAA; wb_hi = 16'h0; ra3 = 4'd3; ra1 = 4'd7;
    expect_next(K_RD3, 16'h1234, "wide_hi_fwd_rd3");
    expect_next(K_RD1, 16'h0000, "busy_ignore_no_fwd");
    expect_next(K_BUSY, 16'd0, "wide_busy_low");
    tick();
    idle_inputs();
    ra1 = 4'd7; ra2 = 4'd2; ra3 = 4'd3;
    expect_next(K_RD1, 16'h0000, "busy_ignore_r7");
    expect_next(K_RD2, 16'h5678, "wide_r2");
    expect_next(K_RD3, 16'h1234, "wide_r3");
    expect_next(K_BUSY, 16'd0, "idle_busy");
    tick();

    // Wrap: wide write at r15 puts the hi word in r0.
    wb_valid = 1; wb_rd = 4'd15; wb_wide = 1; wb_lo = 16'h0F0F; wb_hi = 16'h00FF; ra1 = 4'd15;
    expect_next(K_RD1, 16'h0F0F, "wrap_lo_fwd");
    expect_next(K_BUSY, 16'd1, "wrap_busy");
    tick();
    idle_inputs();
    ra2 = 4'd0;
    expect_next(K_RD2, WRAP_R0, "wrap_hi_fwd_r0");
    tick();
    ra3 = 4'd0; ra1 = 4'd15;
    expect_next(K_RD3, WRAP_R0, "wrap_r0");
    expect_next(K_RD1, 16'h0F0F, "wrap_r15");
    tick();

    // Flags: capture, hold when not enabled, capture a mixed pattern.
    wb_valid = 1; wb_rd = 4'd4; wb_lo = 16'h0001; wb_flags_en = 1; z_in = 1; c_in = 1;
    expect_next(K_FZ, 16'd1, "flags_set_z");
    expect_next(K_FC, 16'd1, "flags_set_c");
    tick();
    wb_valid = 1; wb_rd = 4'd6; wb_lo = 16'h0002; wb_flags_en = 0; z_in = 0; c_in = 0;
    expect_next(K_FZ, 16'd1, "flags_hold_z");
    expect_next(K_FC, 16'd1, "flags_hold_c");
    tick();
    wb_valid = 1; wb_rd = 4'd8; wb_lo = 16'h0003; wb_flags_en = 1; z_in = 0; c_in = 1;
    expect_next(K_FZ, 16'd0, "flags_mix_z");
    expect_next(K_FC, 16'd1, "flags_mix_c");
    tick();

    // Flags are not sampled in WRITE_HI.
    wb_valid = 1; wb_rd = 4'd9; wb_wide = 1; wb_lo = 16'h0001; wb_hi = 16'h0002;
    wb_flags_en = 1; z_in = 1; c_in = 0;
    expect_next(K_FZ, 16'd1, "wide_flags_z");
    expect_next(K_FC, 16'd0, "wide_flags_c");
    tick();
    wb_valid = 1; wb_wide = 0; wb_flags_en = 1; z_in = 0; c_in = 1;
    expect_next(K_FZ, 16'd1, "writehi_flags_z");
    expect_next(K_FC, 16'd0, "writehi_flags_c");
    tick();
    idle_inputs();
    tick();

    // Reset during WRITE_HI discards the hi write and clears flags.
    wb_valid = 1; wb_rd = 4'd10; wb_wide = 1; wb_lo = 16'h1111; wb_hi = 16'h2222;
    wb_flags_en = 1; z_in = 1; c_in = 1;
    expect_next(K_BUSY, 16'd1, "rstwh_busy");
    expect_next(K_FZ, 16'd1, "rstwh_flag_z_pre");
    tick();
    idle_inputs();
    #2 nreset = 1'b0;
    #1;
    check("rstwh_busy_clr", {15'd0, busy}, 16'h0);
    check("rstwh_flag_z", {15'd0, flag_z}, 16'h0);
    check("rstwh_flag_c", {15'd0, flag_c}, 16'h0);
    tick();
    nreset = 1'b1;
    ra1 = 4'd11; ra2 = 4'd10;
    expect_next(K_RD1, 16'h0000, "rstwh_hi_lost");
    expect_next(K_RD2, 16'h0000, "rstwh_lo_cleared");
    expect_next(K_BUSY, 16'd0, "rstwh_busy_after");
    tick();
    tick();

    check("scoreboard_drained", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
